// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loaderState_e : FSM state encoding (3 bits)
//   LDR_ADDR_STEP : byte stride between consecutive payload words
//   HDR_LEN_W     : width of the header length field as it arrives on the stream
//   CNT_W         : width of the payload word counter (0..1024 needs 11 bits)
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      RUN  = 3'd4,
      ERR  = 3'd5
   } loaderState_e;

   localparam int LDR_ADDR_STEP = 4;
   localparam int HDR_LEN_W     = 32;
   localparam int CNT_W         = 11;

endpackage

// File: rtl/prog_loader_if.sv
// Framed word stream into the loader (valid/ready handshake).
//   s_valid : source has a word
//   s_ready : loader takes the word this cycle
//   s_data  : stream word (header, payload or checksum)
//   s_last  : final word of the frame (the checksum word)
// master = stream source, slave = loader.
interface prog_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;

   modport master (output s_valid, output s_data, output s_last, input  s_ready);
   modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot-time instruction loader. Receives header/payload/checksum frames,
// writes the payload into instruction memory and holds the CPU off until
// the checksum matches.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begin a new frame (ignored while busy)
//   strm       : stream slave (s_valid/s_ready/s_data/s_last)
//   mem_we, mem_addr, mem_wdata : registered instruction-memory write port
//   cpu_run    : CPU may execute
//   busy       : frame reception in progress
//   err        : last frame rejected (held until next start)
//   word_cnt   : payload words written in current/last frame
//
// state | meaning
// IDLE  | after reset, nothing loaded
// HDR   | waiting for the length word
// DATA  | receiving payload words, each written to memory
// CSUM  | waiting for the checksum word
// RUN   | frame verified, CPU released
// ERR   | frame rejected, CPU held
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                ADDR_W    = 15,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   prog_loader_if.slave      strm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              err,
   output logic [CNT_W-1:0]  word_cnt
);

   loaderState_e      state, stateNxt;
   logic              accept;
   logic              startTake;
   logic [CNT_W-1:0]  remCnt;
   logic [CNT_W-1:0]  wordCnt;
   logic [31:0]       sum;
   logic [ADDR_W-1:0] addr;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWdata;

   assign accept    = strm.s_valid && strm.s_ready;
   assign startTake = start && (state == IDLE || state == RUN || state == ERR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE, RUN, ERR: if (start) stateNxt = HDR;
         HDR: if (accept) begin
            if (strm.s_last || strm.s_data > HDR_LEN_W'(MAX_WORDS)) stateNxt = ERR;
            else if (strm.s_data == '0)                              stateNxt = CSUM;
            else                                                     stateNxt = DATA;
         end
         // s_last only ever belongs on the checksum word, so seeing it on
         // any payload word (including the final one) rejects the frame.
         DATA: if (accept) begin
            if (strm.s_last)             stateNxt = ERR;
            else if (remCnt == CNT_W'(1)) stateNxt = CSUM;
         end
         CSUM: if (accept) stateNxt = (strm.s_last && strm.s_data == sum) ? RUN : ERR;
         default: stateNxt = IDLE;
      endcase
   end

   always_comb begin
      strm.s_ready = (state == HDR) || (state == DATA) || (state == CSUM);
      busy         = strm.s_ready;
      cpu_run      = (state == RUN);
      err          = (state == ERR);
   end

   // Remaining-word down-counter, running sum, address counter and the
   // registered write port. Words already written stay in memory on error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remCnt   <= '0;
         wordCnt  <= '0;
         sum      <= '0;
         addr     <= '0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
      end else begin
         memWe <= 1'b0;
         if (startTake) begin
            wordCnt <= '0;
            sum     <= '0;
            addr    <= BASE_ADDR;
         end
         if (state == HDR && accept) remCnt <= strm.s_data[CNT_W-1:0];
         if (state == DATA && accept) begin
            memWe    <= 1'b1;
            memAddr  <= addr;
            memWdata <= strm.s_data;
            addr     <= addr + ADDR_W'(LDR_ADDR_STEP);
            sum      <= sum + strm.s_data;
            wordCnt  <= wordCnt + CNT_W'(1);
            remCnt   <= remCnt - CNT_W'(1);
         end
      end
   end

   assign mem_we    = memWe;
   assign mem_addr  = memAddr;
   assign mem_wdata = memWdata;
   assign word_cnt  = wordCnt;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
   import prog_loader_pkg::*;

   typedef struct {
      logic [14:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_run, busy, err;
   logic [10:0] word_cnt;

   int nChecks = 0;
   int nErrors = 0;
   wr_t expQ[$];
   logic [31:0] pay [3];
   logic [31:0] goodSum;

   prog_loader_if ifc ();

   prog_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .strm(ifc),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_run(cpu_run), .busy(busy), .err(err), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: every mem_we pulse must match the next expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (expQ.size() == 0) chk("unexpected_write", {17'd0, mem_addr}, 32'hFFFF_FFFF);
         else begin
            wr_t e;
            e = expQ.pop_front();
            chk("wr_addr", {17'd0, mem_addr}, {17'd0, e.a});
            chk("wr_data", mem_wdata, e.d);
         end
      end
   end

   // Holds one beat on the bus until the loader is ready; acceptance happens
   // on the posedge following return.
   task automatic sendBeat(input logic [31:0] data, input logic last, input bit gaps);
      int tries = 0;
      bit done = 0;
      while (!done) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 2) == 0) ifc.s_valid = 1'b0;
         else begin
            ifc.s_valid = 1'b1;
            ifc.s_data  = data;
            ifc.s_last  = last;
            if (ifc.s_ready) done = 1;
         end
         tries++;
         if (!done && tries > 60) begin
            chk("beat_timeout", 32'd0, 32'd1);
            done = 1;
         end
      end
   endtask

   task automatic idleBus();
      @(negedge clk);
      ifc.s_valid = 1'b0;
      ifc.s_last  = 1'b0;
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_err", {31'd0, err}, 32'd0);
      chk("start_cnt", {21'd0, word_cnt}, 32'd0);
   endtask

   task automatic frame3(input bit gaps, input logic [31:0] csum, input bit expRun);
      sendBeat(32'd3, 1'b0, gaps);
      for (int k = 0; k < 3; k++) begin
         expQ.push_back('{a: 15'(k * 4), d: pay[k]});
         sendBeat(pay[k], 1'b0, gaps);
      end
      sendBeat(csum, 1'b1, gaps);
      chk("run_before_csum", {31'd0, cpu_run}, 32'd0);
      idleBus();
      chk("run_after_csum", {31'd0, cpu_run}, {31'd0, expRun});
      chk("err_after_csum", {31'd0, err}, {31'd0, !expRun});
      chk("busy_after_csum", {31'd0, busy}, 32'd0);
      chk("frame_cnt", {21'd0, word_cnt}, 32'd3);
      chk("pending_writes", expQ.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.s_valid = 1'b0;
      ifc.s_data  = '0;
      ifc.s_last  = 1'b0;
      pay[0] = 32'h2008_0005;
      pay[1] = 32'h2109_0001;
      pay[2] = 32'h0109_5020;
      goodSum = pay[0] + pay[1] + pay[2];

      repeat (3) @(negedge clk);
      chk("rst_run", {31'd0, cpu_run}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_ready", {31'd0, ifc.s_ready}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      rst_n = 1'b1;

      // good frame
      pulseStart();
      frame3(1'b0, goodSum, 1'b1);

      // bad checksum, then recovery
      pulseStart();
      chk("restart_run_clear", {31'd0, cpu_run}, 32'd0);
      frame3(1'b0, 32'h0000_0000, 1'b0);
      pulseStart();
      frame3(1'b0, goodSum, 1'b1);

      // oversize header
      pulseStart();
      sendBeat(32'd1025, 1'b0, 1'b0);
      idleBus();
      chk("oversize_err", {31'd0, err}, 32'd1);
      chk("oversize_ready", {31'd0, ifc.s_ready}, 32'd0);
      chk("oversize_cnt", {21'd0, word_cnt}, 32'd0);

      // empty frame
      pulseStart();
      sendBeat(32'd0, 1'b0, 1'b0);
      sendBeat(32'd0, 1'b1, 1'b0);
      idleBus();
      chk("empty_run", {31'd0, cpu_run}, 32'd1);
      chk("empty_cnt", {21'd0, word_cnt}, 32'd0);

      // early s_last on second payload word
      pulseStart();
      sendBeat(32'd3, 1'b0, 1'b0);
      expQ.push_back('{a: 15'h0, d: pay[0]});
      sendBeat(pay[0], 1'b0, 1'b0);
      expQ.push_back('{a: 15'h4, d: pay[1]});
      sendBeat(pay[1], 1'b1, 1'b0);
      idleBus();
      repeat (2) @(negedge clk);
      chk("early_err", {31'd0, err}, 32'd1);
      chk("early_run", {31'd0, cpu_run}, 32'd0);
      chk("early_cnt", {21'd0, word_cnt}, 32'd2);
      chk("early_pending", expQ.size(), 32'd0);

      // valid gaps on good frame
      pulseStart();
      frame3(1'b1, goodSum, 1'b1);

      // reset mid-DATA after writes
      pulseStart();
      sendBeat(32'd3, 1'b0, 1'b0);
      expQ.push_back('{a: 15'h0, d: pay[0]});
      sendBeat(pay[0], 1'b0, 1'b0);
      expQ.push_back('{a: 15'h4, d: pay[1]});
      sendBeat(pay[1], 1'b0, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_run", {31'd0, cpu_run}, 32'd0);
      chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
      chk("mid_rst_addr", {17'd0, mem_addr}, 32'd0);
      chk("mid_rst_cnt", {21'd0, word_cnt}, 32'd0);
      chk("mid_rst_ready", {31'd0, ifc.s_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ifc.s_valid = 1'b1;
      ifc.s_data  = pay[2];
      repeat (5) @(negedge clk);
      chk("post_rst_ready", {31'd0, ifc.s_ready}, 32'd0);
      chk("post_rst_cnt", {21'd0, word_cnt}, 32'd0);
      ifc.s_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_pending", expQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
